// File: rtl/disp_scan.sv
// disp_scan: four-digit multiplexed seven-segment driver for the tablet dispenser.
// A small FSM snapshots the inputs once per 22-cycle loop, converts two binary
// operands to BCD with double-dabble, and latches the digit codes into the
// display register. An independent scan counter walks the digits, and the
// an/seg/dp outputs are registered together from the same digit index.
// Optional feature: define WARN_BLINK_EN to blank the whole display at the
// BLINK_DIV rate while warning=1. In the default build warning has no effect.
module disp_scan #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       cp,
    input  logic       reset_n,
    input  logic [6:0] qout,
    input  logic [6:0] set,
    input  logic [9:0] count_sum,
    input  logic       choice,
    input  logic       warning,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Internal digit codes: 0..9 are decimal digits, then blank and dash.
    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_A = 2'd1,
        CONV_B = 2'd2,
        LATCH  = 2'd3
    } state_t;

    state_t            state_r;
    logic [3:0]        iter_r;
    logic [25:0]       conv_a_r;    // {bcd[15:0], binary[9:0]}
    logic [25:0]       conv_b_r;
    logic              choice_r;
    logic [15:0]       disp_r;      // digit codes, digit 3 in [15:12]
    logic              disp_dp_r;   // 1 = field mode, dp lit on digit 2
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [1:0]        idx_r;
    logic              blink_on_s;
    logic [3:0]        digit_code_s;
    logic [3:0]        an_next_s;
    logic [6:0]        seg_next_s;
    logic              dp_next_s;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [25:0] dd_step(input logic [25:0] v);
        logic [25:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[10 + 4*i +: 4] >= 4'd5) begin
                t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
            end else begin
                t[10 + 4*i +: 4] = t[10 + 4*i +: 4];
            end
        end
        return {t[24:0], 1'b0};
    endfunction

    // Two-digit field (set or qout): dashes above 99, blank tens when zero.
    function automatic logic [7:0] field_digits(input logic [15:0] bcd);
        logic [7:0] r;
        if ((bcd[15:12] != 4'd0) || (bcd[11:8] != 4'd0)) begin
            r = {CODE_DASH, CODE_DASH};
        end else if (bcd[7:4] == 4'd0) begin
            r = {CODE_BLANK, bcd[3:0]};
        end else begin
            r = {bcd[7:4], bcd[3:0]};
        end
        return r;
    endfunction

    // Four-digit total with leading-zero blanking; the ones digit always shows.
    function automatic logic [15:0] sum_digits(input logic [15:0] bcd);
        logic [15:0] r;
        r[3:0]   = bcd[3:0];
        r[7:4]   = (bcd[15:4] == 12'd0) ? CODE_BLANK : bcd[7:4];
        r[11:8]  = (bcd[15:8] == 8'd0)  ? CODE_BLANK : bcd[11:8];
        r[15:12] = (bcd[15:12] == 4'd0) ? CODE_BLANK : bcd[15:12];
        return r;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for a digit code.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:      s = 7'b1000000;
            4'd1:      s = 7'b1111001;
            4'd2:      s = 7'b0100100;
            4'd3:      s = 7'b0110000;
            4'd4:      s = 7'b0011001;
            4'd5:      s = 7'b0010010;
            4'd6:      s = 7'b0000010;
            4'd7:      s = 7'b1111000;
            4'd8:      s = 7'b0000000;
            4'd9:      s = 7'b0010000;
            CODE_DASH: s = 7'b0111111;
            default:   s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM: snapshot inputs, convert A then B, latch display register.
    always_ff @(posedge cp or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            iter_r    <= 4'd0;
            conv_a_r  <= 26'd0;
            conv_b_r  <= 26'd0;
            choice_r  <= 1'b0;
            disp_r    <= {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};
            disp_dp_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    choice_r <= choice;
                    conv_a_r <= {16'd0, (choice ? count_sum : {3'd0, set})};
                    conv_b_r <= {16'd0, 3'd0, qout};
                    iter_r   <= 4'd0;
                    state_r  <= CONV_A;
                end
                CONV_A: begin
                    conv_a_r <= dd_step(conv_a_r);
                    if (iter_r == 4'd9) begin
                        iter_r  <= 4'd0;
                        state_r <= CONV_B;
                    end else begin
                        iter_r  <= iter_r + 4'd1;
                    end
                end
                CONV_B: begin
                    conv_b_r <= dd_step(conv_b_r);
                    if (iter_r == 4'd9) begin
                        iter_r  <= 4'd0;
                        state_r <= LATCH;
                    end else begin
                        iter_r  <= iter_r + 4'd1;
                    end
                end
                LATCH: begin
                    if (choice_r) begin
                        disp_r <= sum_digits(conv_a_r[25:10]);
                    end else begin
                        disp_r <= {field_digits(conv_a_r[25:10]), field_digits(conv_b_r[25:10])};
                    end
                    disp_dp_r <= ~choice_r;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Scan timer: dwell SCAN_DIV cycles on each digit, then step to the next.
    always_ff @(posedge cp or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_r <= '0;
            idx_r      <= 2'd0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

`ifdef WARN_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_on_r;

    // Blink timer: toggles the on/off phase while warning is high, parked on otherwise.
    always_ff @(posedge cp or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (!warning) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    assign blink_on_s = blink_on_r;
`else
    // Without the blink feature the display is always on; the OR folds to 1.
    assign blink_on_s = warning | 1'b1;
`endif

    // Next-output decode for the current digit index.
    always_comb begin
        digit_code_s = CODE_BLANK;
        an_next_s    = 4'b1111;
        case (idx_r)
            2'd0: begin digit_code_s = disp_r[3:0];   an_next_s = 4'b1110; end
            2'd1: begin digit_code_s = disp_r[7:4];   an_next_s = 4'b1101; end
            2'd2: begin digit_code_s = disp_r[11:8];  an_next_s = 4'b1011; end
            2'd3: begin digit_code_s = disp_r[15:12]; an_next_s = 4'b0111; end
            default: begin digit_code_s = CODE_BLANK; an_next_s = 4'b1111; end
        endcase
        seg_next_s = seg_decode(digit_code_s);
        dp_next_s  = ~(disp_dp_r & (idx_r == 2'd2));
        if (!blink_on_s) begin
            an_next_s  = 4'b1111;
            seg_next_s = 7'b1111111;
            dp_next_s  = 1'b1;
        end else begin
            an_next_s  = an_next_s;
        end
    end

    // Output register: an, seg and dp change together on the same edge.
    always_ff @(posedge cp or negedge reset_n) begin
        if (!reset_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next_s;
            seg <= seg_next_s;
            dp  <= dp_next_s;
        end
    end

endmodule
